// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: shifts one 64-bit read/write frame per command
// out on MDC_Clk/MDIO and returns the read data with a no-PHY-response flag.
module mdio_master #(
  parameter int CLK_DIV = 50
) (
  input  logic        AXI_Clk,
  input  logic        AXI_Rstn,
  input  logic        Cmd_Valid,
  output logic        Cmd_Ready,
  input  logic        Cmd_Write,
  input  logic [4:0]  Cmd_Phy_Addr,
  input  logic [4:0]  Cmd_Reg_Addr,
  input  logic [15:0] Cmd_Wdata,
  output logic        Rsp_Valid,
  output logic [15:0] Rsp_Rdata,
  output logic        Rsp_Err,
  output logic        Busy,
  output logic        MDC_Clk,
  output logic        MDIO_O,
  output logic        MDIO_T,
  input  logic        MDIO_I,
  output logic [2:0]  Dbg_State
);
  // Handshake: a command transfers on the edge where Cmd_Valid and Cmd_Ready are both
  // high; Rsp_Valid is a one-cycle pulse with no back-pressure from the consumer.
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t          state;
  logic [63:0]     shift;
  logic            is_read;
  logic [5:0]      bit_cnt;
  logic [5:0]      nxt_bit;
  logic [DW-1:0]   div_cnt;
  logic [1:0]      sync_q;
  logic [15:0]     rx;
  logic            rx_err;
  logic [15:0]     rx_next;
  logic            err_next;
  logic            capture;

  assign Busy      = ~Cmd_Ready;
  assign Dbg_State = state;

  function automatic state_t phase_of(input logic [5:0] b);
    if (b < 6'd32)      return S_PRE;
    else if (b < 6'd46) return S_HDR;
    else if (b < 6'd48) return S_TA;
    else                return S_DATA;
  endfunction

  always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
    if (!AXI_Rstn) sync_q <= 2'b11;
    else           sync_q <= {sync_q[0], MDIO_I};
  end

  // The capture lands on the edge that makes the synchronized value two cycles after the
  // MDC rise; computing rx_next here lets the last data bit reach Rsp_Rdata on DONE entry.
  always_comb begin
    capture  = MDC_Clk && (div_cnt == DW'(1)) && is_read &&
               (state != S_IDLE) && (state != S_DONE);
    rx_next  = rx;
    err_next = rx_err;
    if (capture && (bit_cnt == 6'd47)) err_next = sync_q[1];
    if (capture && (bit_cnt >= 6'd48)) rx_next = {rx[14:0], sync_q[1]};
    nxt_bit  = bit_cnt + 6'd1;
  end

  always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
    if (!AXI_Rstn) begin
      state     <= S_IDLE;
      shift     <= '0;
      is_read   <= 1'b0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      rx        <= '0;
      rx_err    <= 1'b0;
      Cmd_Ready <= 1'b1;
      Rsp_Valid <= 1'b0;
      Rsp_Rdata <= '0;
      Rsp_Err   <= 1'b0;
      MDC_Clk   <= 1'b0;
      MDIO_O    <= 1'b1;
      MDIO_T    <= 1'b1;
    end else begin
      Rsp_Valid <= 1'b0;
      rx        <= rx_next;
      rx_err    <= err_next;
      case (state)
        S_IDLE: begin
          if (Cmd_Valid) begin
            // Read frames carry all-ones in TA/DATA; the pad is released there anyway.
            shift     <= {32'hFFFF_FFFF, 2'b01,
                          (Cmd_Write ? 2'b01 : 2'b10),
                          Cmd_Phy_Addr, Cmd_Reg_Addr,
                          (Cmd_Write ? 2'b10 : 2'b11),
                          (Cmd_Write ? Cmd_Wdata : 16'hFFFF)};
            is_read   <= ~Cmd_Write;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            MDC_Clk   <= 1'b0;
            MDIO_O    <= 1'b1;
            MDIO_T    <= 1'b0;
            Cmd_Ready <= 1'b0;
            state     <= S_PRE;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          Cmd_Ready <= 1'b1;
        end
        default: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            MDC_Clk <= ~MDC_Clk;
            if (MDC_Clk) begin
              if (bit_cnt == 6'd63) begin
                state     <= S_DONE;
                Rsp_Valid <= 1'b1;
                MDIO_T    <= 1'b1;
                MDIO_O    <= 1'b1;
                Rsp_Rdata <= is_read ? rx_next : 16'h0000;
                Rsp_Err   <= is_read & err_next;
              end else begin
                bit_cnt <= nxt_bit;
                shift   <= {shift[62:0], 1'b0};
                MDIO_O  <= shift[62];
                MDIO_T  <= is_read && (nxt_bit >= 6'd46);
                state   <= phase_of(nxt_bit);
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: two instances (CLK_DIV=4 and CLK_DIV=2), a PHY model on the
// pad, and a response scoreboard checking data, error flag, pad/tristate streams and latency.
module tb_mdio_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_write [2];
  logic [4:0]  cmd_phy   [2];
  logic [4:0]  cmd_reg   [2];
  logic [15:0] cmd_wdata [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];
  logic        mdc       [2];
  logic        mdio_o    [2];
  logic        mdio_t    [2];
  logic        mdio_i    [2];
  logic [2:0]  dbg_state [2];

  logic        phy_present [2];
  logic [15:0] phy_data    [2];
  logic [5:0]  idx         [2];

  mdio_master #(.CLK_DIV(4)) u_div4 (
    .AXI_Clk(clk), .AXI_Rstn(rst_n),
    .Cmd_Valid(cmd_valid[0]), .Cmd_Ready(cmd_ready[0]), .Cmd_Write(cmd_write[0]),
    .Cmd_Phy_Addr(cmd_phy[0]), .Cmd_Reg_Addr(cmd_reg[0]), .Cmd_Wdata(cmd_wdata[0]),
    .Rsp_Valid(rsp_valid[0]), .Rsp_Rdata(rsp_rdata[0]), .Rsp_Err(rsp_err[0]),
    .Busy(busy[0]), .MDC_Clk(mdc[0]), .MDIO_O(mdio_o[0]), .MDIO_T(mdio_t[0]),
    .MDIO_I(mdio_i[0]), .Dbg_State(dbg_state[0])
  );

  mdio_master #(.CLK_DIV(2)) u_div2 (
    .AXI_Clk(clk), .AXI_Rstn(rst_n),
    .Cmd_Valid(cmd_valid[1]), .Cmd_Ready(cmd_ready[1]), .Cmd_Write(cmd_write[1]),
    .Cmd_Phy_Addr(cmd_phy[1]), .Cmd_Reg_Addr(cmd_reg[1]), .Cmd_Wdata(cmd_wdata[1]),
    .Rsp_Valid(rsp_valid[1]), .Rsp_Rdata(rsp_rdata[1]), .Rsp_Err(rsp_err[1]),
    .Busy(busy[1]), .MDC_Clk(mdc[1]), .MDIO_O(mdio_o[1]), .MDIO_T(mdio_t[1]),
    .MDIO_I(mdio_i[1]), .Dbg_State(dbg_state[1])
  );

  // Pad: master drives when MDIO_T=0; otherwise the PHY drives TA bit 2 (0) and the
  // data bits, and a pull-up gives 1 everywhere else.
  for (genvar g = 0; g < 2; g++) begin : g_pad
    assign mdio_i[g] = mdio_t[g] ?
        ((phy_present[g] && (idx[g] >= 6'd47)) ?
           ((idx[g] == 6'd47) ? 1'b0 : phy_data[g][4'(6'd63 - idx[g])]) : 1'b1) :
        mdio_o[g];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [144:0] exp_q0 [$];
  logic [144:0] exp_q1 [$];

  int          acc_cyc [2];
  int          hi_run  [2];
  int          lo_run  [2];
  int          rsp_cnt [2];
  logic        mdc_prev [2];
  logic [63:0] cap_pad [2];
  logic [63:0] cap_t   [2];
  logic [144:0] mon_e;

  function automatic int div_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic logic [144:0] mk(input logic [63:0] pad, input logic [63:0] t,
                                      input logic err, input logic [15:0] rdata);
    return {pad, t, err, rdata};
  endfunction

  task automatic chk(input string name, input int d, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h required %0h", name, d, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [144:0] e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Monitor: PHY bit tracking, MDC period checks, stream capture, response scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        idx[d]      = '0;
        mdc_prev[d] = 1'b0;
        hi_run[d]   = 0;
        lo_run[d]   = 100;
      end else begin
        if (cmd_valid[d] && cmd_ready[d]) acc_cyc[d] = cyc;
        if (!mdc_prev[d] && mdc[d]) begin
          checks++;
          if (lo_run[d] < div_of(d)) begin
            errors++;
            $display("FAIL mdc_low_time dut%0d: got %0d required >= %0d", d, lo_run[d], div_of(d));
          end
          lo_run[d]  = 0;
          cap_pad[d] = {cap_pad[d][62:0], mdio_i[d]};
          cap_t[d]   = {cap_t[d][62:0], mdio_t[d]};
        end
        if (mdc_prev[d] && !mdc[d]) begin
          chk("mdc_high_time", d, 64'(hi_run[d]), 64'(div_of(d)));
          hi_run[d] = 0;
          idx[d]    = idx[d] + 6'd1;
        end
        if (mdc[d]) hi_run[d]++;
        else        lo_run[d]++;
        if (cmd_ready[d]) idx[d] = '0;
        mdc_prev[d] = mdc[d];
        if (rsp_valid[d]) begin
          rsp_cnt[d]++;
          if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp dut%0d: got rdata %0h with no response pending", d, rsp_rdata[d]);
          end else begin
            if (d == 0) mon_e = exp_q0.pop_front();
            else        mon_e = exp_q1.pop_front();
            chk("pad_stream", d, cap_pad[d], mon_e[144:81]);
            chk("t_stream",   d, cap_t[d],   mon_e[80:17]);
            chk("rsp_err",    d, 64'(rsp_err[d]),   64'(mon_e[16]));
            chk("rsp_rdata",  d, 64'(rsp_rdata[d]), 64'(mon_e[15:0]));
            chk("latency",    d, 64'(cyc - acc_cyc[d]), 64'(128 * div_of(d) + 1));
          end
        end
      end
    end
  end

  task automatic send(input int d, input logic wr, input logic [4:0] pa,
                      input logic [4:0] ra, input logic [15:0] wd);
    bit ok;
    ok = 1'b0;
    cmd_write[d] = wr;
    cmd_phy[d]   = pa;
    cmd_reg[d]   = ra;
    cmd_wdata[d] = wd;
    cmd_valid[d] = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (cmd_ready[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", d, 64'(0), 64'(1));
    @(posedge clk);
    #1 cmd_valid[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d);
    int start;
    bit ok;
    start = rsp_cnt[d];
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (rsp_cnt[d] != start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", d, 64'(0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag, input int d);
    chk({tag, "_cmd_ready"}, d, 64'(cmd_ready[d]), 64'(1));
    chk({tag, "_busy"},      d, 64'(busy[d]),      64'(0));
    chk({tag, "_rsp_valid"}, d, 64'(rsp_valid[d]), 64'(0));
    chk({tag, "_mdc"},       d, 64'(mdc[d]),       64'(0));
    chk({tag, "_mdio_o"},    d, 64'(mdio_o[d]),    64'(1));
    chk({tag, "_mdio_t"},    d, 64'(mdio_t[d]),    64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rsp_at;
    bit ok;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_write[d] = 1'b0; cmd_phy[d] = '0; cmd_reg[d] = '0;
      cmd_wdata[d] = '0; phy_present[d] = 1'b0; phy_data[d] = '0;
      rsp_cnt[d] = 0; acc_cyc[d] = 0; cap_pad[d] = '0; cap_t[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk_reset_outputs("reset", d);
      chk("reset_rdata", d, 64'(rsp_rdata[d]), 64'(0));
      chk("reset_err",   d, 64'(rsp_err[d]),   64'(0));
    end

    // Write PHY=1 REG=0 DATA=0x1140.
    push_exp(0, mk(64'hFFFF_FFFF_5082_1140, 64'h0, 1'b0, 16'h0000));
    send(0, 1'b1, 5'd1, 5'd0, 16'h1140);
    wait_rsp(0);

    // Read PHY=1 REG=1, PHY answers 0x796D.
    phy_present[0] = 1'b1; phy_data[0] = 16'h796D;
    push_exp(0, mk(64'hFFFF_FFFF_6086_796D, 64'h0000_0000_0003_FFFF, 1'b0, 16'h796D));
    send(0, 1'b0, 5'd1, 5'd1, 16'h0000);
    wait_rsp(0);

    // Read with no PHY: pull-up everywhere after the header.
    phy_present[0] = 1'b0;
    push_exp(0, mk(64'hFFFF_FFFF_610F_FFFF, 64'h0000_0000_0003_FFFF, 1'b1, 16'hFFFF));
    send(0, 1'b0, 5'd2, 5'd3, 16'h0000);
    wait_rsp(0);

    // Cmd_Valid held across a write followed by a read.
    phy_present[0] = 1'b1; phy_data[0] = 16'h1234;
    push_exp(0, mk(64'hFFFF_FFFF_5192_BEEF, 64'h0, 1'b0, 16'h0000));
    push_exp(0, mk(64'hFFFF_FFFF_608A_1234, 64'h0000_0000_0003_FFFF, 1'b0, 16'h1234));
    cmd_write[0] = 1'b1; cmd_phy[0] = 5'd3; cmd_reg[0] = 5'd4; cmd_wdata[0] = 16'hBEEF;
    cmd_valid[0] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 cmd_write[0] = 1'b0; cmd_phy[0] = 5'd1; cmd_reg[0] = 5'd2; cmd_wdata[0] = 16'h0000;
    ok = 1'b0;
    rsp_at = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin
        ok = 1'b1;
        rsp_at = cyc;
        break;
      end
    end
    if (!ok) chk("b2b_rsp_timeout", 0, 64'(0), 64'(1));
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cmd_ready[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("b2b_accept_timeout", 0, 64'(0), 64'(1));
    chk("b2b_gap", 0, 64'(cyc - rsp_at), 64'(1));
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0;
    wait_rsp(0);

    // Reset in the middle of a write (around bit 20), no response expected.
    send(0, 1'b1, 5'd1, 5'd0, 16'h1140);
    repeat (100) @(posedge clk);
    #1;
    chk("mid_busy",   0, 64'(busy[0]),   64'(1));
    chk("mid_mdio_t", 0, 64'(mdio_t[0]), 64'(0));
    repeat (64) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("abort", 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_abort_busy", 0, 64'(busy[0]), 64'(0));
    chk("post_abort_mdc",  0, 64'(mdc[0]),  64'(0));
    phy_present[0] = 1'b1; phy_data[0] = 16'h796D;
    push_exp(0, mk(64'hFFFF_FFFF_6086_796D, 64'h0000_0000_0003_FFFF, 1'b0, 16'h796D));
    send(0, 1'b0, 5'd1, 5'd1, 16'h0000);
    wait_rsp(0);

    // CLK_DIV=2 instance: read 0xA5A5, then a write that clears Rsp_Rdata.
    phy_present[1] = 1'b1; phy_data[1] = 16'hA5A5;
    push_exp(1, mk(64'hFFFF_FFFF_629A_A5A5, 64'h0000_0000_0003_FFFF, 1'b0, 16'hA5A5));
    send(1, 1'b0, 5'd5, 5'd6, 16'h0000);
    wait_rsp(1);
    push_exp(1, mk(64'hFFFF_FFFF_507E_0001, 64'h0, 1'b0, 16'h0000));
    send(1, 1'b1, 5'd0, 5'd31, 16'h0001);
    wait_rsp(1);

    repeat (10) @(posedge clk);
    #1;
    chk("exp_q0_drained", 0, 64'(exp_q0.size()), 64'(0));
    chk("exp_q1_drained", 1, 64'(exp_q1.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
